rem_seq_ctrl: RTL and testbench

REM_SEQ_CTRL -- requirements
Module: rem_seq_ctrl

---
 rtl/rem_seq_ctrl_if.sv | 27 ++
 rtl/rem_seq_ctrl.sv | 97 +++++++++
 tb/tb_rem_seq_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rem_seq_ctrl_if.sv
// Purpose : request/result bundle between a requester and the remainder sequencer.
// Signals : start, A, B      - requester -> sequencer (pulse + operands)
//           busy, done, err,
//           out, quo         - sequencer -> requester (status + last result)
// Modports: master (requester side), slave (sequencer side).
interface rem_seq_ctrl_if #(
    parameter int unsigned W = 3
);
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic         err;
    logic [W:0]   out;
    logic [W-1:0] quo;

    modport master (
        output start, A, B,
        input  busy, done, err, out, quo
    );

    modport slave (
        input  start, A, B,
        output busy, done, err, out, quo
    );
endinterface

// File: rtl/rem_seq_ctrl.sv
// Purpose : sequential unsigned divider by repeated subtraction; returns
//           remainder (out), quotient (quo) and a divide-by-zero flag (err).
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - rem_seq_ctrl_if.slave (start/A/B in; busy/done/err/out/quo out)
module rem_seq_ctrl #(
    parameter int unsigned W = 3
) (
    input  logic           clk,
    input  logic           rst,
    rem_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SUB   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_rem;
    logic [W-1:0] r_div;
    logic [W-1:0] r_quo;
    logic         r_busy;
    logic         r_done;
    logic         r_err;
    logic [W:0]   r_out;
    logic [W-1:0] r_quo_out;

    // Sequencer: all state and outputs registered. busy is set/cleared on the
    // same edges that enter/leave CHECK/SUB so it tracks the state exactly.
    // done is registered from DONE, so the strobe trails the DONE state by one
    // cycle; results are already loaded by then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_div     <= '0;
            r_quo     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_out     <= '0;
            r_quo_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_rem   <= bus.A;
                        r_div   <= bus.B;
                        r_quo   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (r_div == '0) begin
                        r_err     <= 1'b1;
                        r_out     <= '0;
                        r_quo_out <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= DONE;
                    end else begin
                        r_state <= SUB;
                    end
                end
                SUB: begin
                    if (r_rem >= r_div) begin
                        r_rem <= r_rem - r_div;
                        r_quo <= r_quo + W'(1);
                    end else begin
                        // Result, quotient and error flag publish together.
                        r_out     <= {1'b0, r_rem};
                        r_quo_out <= r_quo;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.out  = r_out;
    assign bus.quo  = r_quo_out;

endmodule

// File: tb/tb_rem_seq_ctrl.sv
// Purpose : scoreboard bench for rem_seq_ctrl. The driver pushes the expected
//           result of each accepted request; a monitor pops and compares on
//           every done strobe, including the latency from the accepting edge.
module tb_rem_seq_ctrl;

    localparam int unsigned W = 3;

    typedef struct {
        int out;
        int quo;
        int err;
        int lat;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_out = 0;
    int   last_quo = 0;
    int   last_err = 0;
    exp_t exp_q[$];

    rem_seq_ctrl_if #(.W(W)) bus ();

    rem_seq_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done strobe must match the oldest outstanding request.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out", int'(bus.out), e.out);
                check("quo", int'(bus.quo), e.quo);
                check("err", int'(bus.err), e.err);
                check("latency", cyc - e.acc, e.lat);
            end
        end
    end

    // Issue one request; optionally poke start while the operation runs.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        exp_t e;
        int   busy_cnt;
        int   exp_busy;
        bit   seen;
        int   inj_at;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        if (b == 0) begin
            e.out = 0; e.quo = 0; e.err = 1; e.lat = 2; exp_busy = 1;
        end else begin
            e.out = int'(a) % int'(b);
            e.quo = int'(a) / int'(b);
            e.err = 0;
            e.lat = e.quo + 3;
            exp_busy = e.quo + 2;
        end
        e.acc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        // Previous result must survive until this operation completes.
        check("hold_out", int'(bus.out), last_out);
        check("hold_quo", int'(bus.quo), last_quo);
        check("hold_err", int'(bus.err), last_err);
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        seen     = 1'b0;
        inj_at   = 2;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (inject && k == inj_at) begin
                bus.start = 1'b1;
                bus.A     = W'($urandom);
                bus.B     = W'($urandom);
            end else begin
                bus.A     = W'($urandom);
                bus.B     = W'($urandom);
            end
        end
        bus.start = 1'b0;
        if (!seen) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
        check("busy_cycles", busy_cnt, exp_busy);
        last_out = e.out;
        last_quo = e.quo;
        last_err = e.err;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_err"},  int'(bus.err),  0);
        check({tag, "_out"},  int'(bus.out),  0);
        check({tag, "_quo"},  int'(bus.quo),  0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        run_op(3'd0, 3'd1, 1'b0);
        run_op(3'd5, 3'd2, 1'b0);
        run_op(3'd7, 3'd1, 1'b0);
        run_op(3'd6, 3'd0, 1'b0);
        run_op(3'd3, 3'd2, 1'b0);
        // Mid-operation start must be ignored.
        run_op(3'd7, 3'd1, 1'b1);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 3'd7;
        bus.B     = 3'd1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", int'(bus.busy), 1);
        check("pre_rst_quo", int'(bus.quo), 7);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        last_out = 0;
        last_quo = 0;
        last_err = 0;
        repeat (15) @(negedge clk);
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_queue", exp_q.size(), 0);

        // Full operand sweep.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                run_op(W'(a), W'(b), 1'b0);
            end
        end

        // Randomized traffic with idle gaps and stray start pulses.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
